mem_readout: RTL and testbench
==============================

# mem_readout

Memory readback streamer: on a trigger, scans the parameter memory and emits a UART byte stream in the same framing the host uses for writes. Framing is a 0xFF sync byte, then one address byte and one data byte per word. It sits between the parameter memory's read port and the UART transmitter, so the host can verify or log PID coefficients and state. Data bytes equal to 0xFF are saturated to 0xFE so that a data byte is never mistaken for sync.

## Interface
Parameters:
- ADDR_W, 5, memory address width; address byte = zero-extended address
- NUM_WORDS, 32, words per frame; scan covers addresses 0..NUM_WORDS-1; legal range 1..2^ADDR_W
- PERIOD, 0, idle cycles between automatic frames; 0 = trigger-only

Ports:
- clk_in  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  frame request, sampled in IDLE only
- mem_rd_en  out  1  memory read strobe
- mem_rd_addr  out  ADDR_W  memory read address
- mem_rd_data  in  8  read data, valid the cycle after mem_rd_en
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid; held with tx_data until accepted
- tx_ready  in  1  transmitter accepts the byte in a cycle where tx_valid && tx_ready
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last data byte is accepted

## Operation
- State machine: IDLE, SYNC, RD_REQ, RD_WAIT, SEND_ADDR, SEND_DATA, DONE.
- IDLE → SYNC on trigger. Trigger = start, or the period timer expiring when PERIOD>0. The word index idx clears to 0 on this transition.
- SYNC: tx_data=0xFF, tx_valid=1. On accept → RD_REQ.
- RD_REQ: mem_rd_en=1 and mem_rd_addr=idx for exactly this one cycle → RD_WAIT.
- RD_WAIT: mem_rd_data captured into a data register; 0xFF is stored as 0xFE. Always → SEND_ADDR.
- SEND_ADDR: tx_data={zeros, idx}, tx_valid=1. On accept → SEND_DATA.
- SEND_DATA: tx_data=captured data, tx_valid=1. On accept:
  - if idx==NUM_WORDS-1 → DONE;
  - else idx+1 → RD_REQ.
- DONE: frame_done=1 for one cycle → IDLE.
- Period timer:
  - counts clk_in cycles only in IDLE; held at 0 outside IDLE;
  - expires when count==PERIOD-1, which generates the trigger and clears the count.
- start and timer expiry in the same cycle produce one frame.
- start outside IDLE is ignored, not queued.
- Outputs are registered or decoded from state; none depends combinationally on tx_ready.

## Timing
- Reset values:
  - state=IDLE, idx=0, timer=0;
  - tx_valid=0, tx_data=0x00;
  - mem_rd_en=0, mem_rd_addr=0;
  - busy=0, frame_done=0.
- Reset mid-frame: tx_valid drops asynchronously; no partial frame resumes after reset. The host recovers on the next 0xFF.
- start sampled high at edge k → SYNC with tx_valid=1 from cycle k+1.
- With tx_ready held high:
  - the sync byte is accepted in its first valid cycle;
  - each word takes 4 cycles (RD_REQ, RD_WAIT, SEND_ADDR, SEND_DATA).
- Frame length with tx_ready held high: 1 + 4·NUM_WORDS + 1 cycles from SYNC entry through DONE. That is 130 cycles at default.
- Back-pressure:
  - tx_valid and tx_data stay stable while tx_ready=0;
  - tx_valid never deasserts without an accept, except on reset.
- Memory contents may change mid-frame; each word reflects the value read in its own RD_REQ.
- The address byte never exceeds NUM_WORDS-1. No byte other than sync equals 0xFF.
- With PERIOD=P>0 and tx_ready high: next SYNC entry occurs P cycles after DONE→IDLE.

## Test plan
- Reset then single frame. Memory[i]=i+0x10, NUM_WORDS=4, tx_ready=1, pulse start.
  - Bytes: FF,00,10,01,11,02,12,03,13.
  - frame_done pulses once; busy high for 18 cycles.
- Saturation. Memory[2]=0xFF, memory[3]=0xFE → both data bytes transmitted as 0xFE.
- Back-pressure. tx_ready toggles 1,0,0,1 pseudo-randomly → byte sequence identical to the no-stall case; tx_data is never changed while valid and unaccepted.
- start ignored while busy. Pulse start again mid-frame → exactly one frame emitted; no SYNC until the next trigger after IDLE.
- Periodic mode. PERIOD=10, start tied low → frames begin 10 cycles after each DONE→IDLE. Coincident start and expiry gives one frame.
- Reset mid-frame. Assert reset while in SEND_DATA for idx=1:
  - tx_valid=0 and busy=0 immediately;
  - after release the next start yields a full frame beginning with FF,00.

Source files
------------

// File: rtl/mem_readout.sv
// mem_readout: streams parameter memory to the UART as FF sync + (address, data) byte pairs
// Ports: clk_in, reset (async, active-high); start (frame request, honoured in IDLE only);
//   mem_rd_en/mem_rd_addr/mem_rd_data (read port, data one cycle after strobe);
//   tx_data/tx_valid/tx_ready (UART byte handshake); busy (not IDLE); frame_done (end-of-frame pulse).
module mem_readout #(
  parameter int ADDR_W    = 5,
  parameter int NUM_WORDS = 32,
  parameter int PERIOD    = 0
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              frame_done
);
  localparam int TW = PERIOD > 1 ? $clog2(PERIOD) : 1;
  typedef enum logic [2:0] {IDLE, SYNC, RD_REQ, RD_WAIT, SEND_ADDR, SEND_DATA, DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        data_q, data_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              expire, trig, last;
  assign expire = (PERIOD > 0) && (timer_q == TW'(PERIOD - 1));
  assign trig   = start || expire;
  assign last   = idx_q == ADDR_W'(NUM_WORDS - 1);
  // Outputs decode straight from state so nothing depends combinationally on tx_ready
  assign tx_valid    = state_q == SYNC || state_q == SEND_ADDR || state_q == SEND_DATA;
  assign tx_data     = state_q == SYNC      ? 8'hFF :
                       state_q == SEND_ADDR ? 8'(idx_q) :
                       state_q == SEND_DATA ? data_q : 8'h00;
  assign mem_rd_en   = state_q == RD_REQ;
  assign mem_rd_addr = idx_q;
  assign busy        = state_q != IDLE;
  assign frame_done  = state_q == DONE;
  // The timer only runs while idle; a trigger from either source restarts it at zero
  assign timer_d = (PERIOD > 0 && state_q == IDLE && !trig) ? timer_q + 1'b1 : '0;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      IDLE:      if (trig) begin
                   state_d = SYNC;
                   idx_d   = '0;
                 end
      SYNC:      state_d = tx_ready ? RD_REQ : SYNC;
      RD_REQ:    state_d = RD_WAIT;
      RD_WAIT:   begin
                   data_d  = mem_rd_data == 8'hFF ? 8'hFE : mem_rd_data;
                   state_d = SEND_ADDR;
                 end
      SEND_ADDR: state_d = tx_ready ? SEND_DATA : SEND_ADDR;
      SEND_DATA: if (tx_ready) begin
                   state_d = last ? DONE : RD_REQ;
                   idx_d   = last ? idx_q : idx_q + 1'b1;
                 end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      timer_q <= timer_d;
    end
  end
endmodule

// File: tb/tb_mem_readout.sv
// tb_mem_readout: randomized self-checking bench for mem_readout against a byte-stream model
module tb_mem_readout;
  localparam int AW = 5, NW = 4, NWP = 2, P = 10;
  typedef logic [7:0] bq_t[$];
  logic clk_in = 0, reset = 1, start = 0, tx_ready = 0, start_p = 0, rand_ready = 0;
  logic mem_rd_en, mem_rd_en_p, tx_valid, tx_valid_p, busy, busy_p, frame_done, frame_done_p;
  logic [AW-1:0] mem_rd_addr, mem_rd_addr_p;
  logic [7:0] mem_rd_data, mem_rd_data_p, tx_data, tx_data_p;
  logic [7:0] mem [32];
  bq_t q, qp, e;
  int cyc = 0, done_cyc[$], sync_cyc[$];
  int tests = 0, fails = 0;
  logic pv = 0, pr = 0, pb = 0;
  logic [7:0] pd = 0;

  always #5 clk_in = ~clk_in;

  mem_readout #(.ADDR_W(AW), .NUM_WORDS(NW), .PERIOD(0)) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done));

  mem_readout #(.ADDR_W(AW), .NUM_WORDS(NWP), .PERIOD(P)) dut_p (
    .clk_in(clk_in), .reset(reset), .start(start_p), .mem_rd_en(mem_rd_en_p), .mem_rd_addr(mem_rd_addr_p),
    .mem_rd_data(mem_rd_data_p), .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(1'b1),
    .busy(busy_p), .frame_done(frame_done_p));

  always @(posedge clk_in) begin
    cyc++;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (mem_rd_en_p) mem_rd_data_p <= mem[mem_rd_addr_p];
  end

  always @(posedge clk_in) if (rand_ready) begin
    #1 tx_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk_in) begin
    if (tx_valid && tx_ready) q.push_back(tx_data);
    if (tx_valid_p) qp.push_back(tx_data_p);
    if (pv && !pr && !reset) begin
      tests++;
      if (!tx_valid || tx_data !== pd) begin
        fails++;
        $display("FAIL hold: valid=%0b data=%02h, required valid=1 data=%02h", tx_valid, tx_data, pd);
      end
    end
    pv = tx_valid; pr = tx_ready; pd = tx_data;
    if (frame_done_p) done_cyc.push_back(cyc);
    if (busy_p && !pb) sync_cyc.push_back(cyc);
    pb = busy_p;
  end

  function automatic bq_t model(int n);
    bq_t r;
    r.push_back(8'hFF);
    for (int i = 0; i < n; i++) begin
      r.push_back(8'(i));
      r.push_back(mem[i] == 8'hFF ? 8'hFE : mem[i]);
    end
    return r;
  endfunction

  task automatic run_frame(input int bound, output int nb, output int nd);
    q.delete(); nb = 0; nd = 0;
    @(posedge clk_in); #1 start = 1;
    @(posedge clk_in); #1 start = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_in);
      if (busy) nb++;
      if (frame_done) nd++;
      if (!busy) break;
    end
  endtask

  task automatic test_reset;
    reset = 1; tx_ready = 0;
    repeat (2) @(posedge clk_in);
    #1;
    tests++;
    if ({tx_valid, tx_data, mem_rd_en, mem_rd_addr, busy, frame_done} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%0b data=%02h rd_en=%0b addr=%0d busy=%0b done=%0b, required all 0",
               tx_valid, tx_data, mem_rd_en, mem_rd_addr, busy, frame_done);
    end
    reset = 0;
    repeat (5) @(posedge clk_in);
    #1;
    tests++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%0b valid=%0b, required 0 0", busy, tx_valid);
    end
  endtask

  task automatic test_single;
    int nb = 0, nd = 0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i + 16);
    tx_ready = 1; q.delete();
    @(posedge clk_in); #1 start = 1;
    @(posedge clk_in); #1 start = 0;
    tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hFF) begin
      fails++;
      $display("FAIL single_sync_latency: valid=%0b data=%02h, required 1 ff", tx_valid, tx_data);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (busy) nb++;
      if (frame_done) nd++;
      if (!busy) break;
    end
    tests++;
    if (nb != 2 + 4 * NW) begin fails++; $display("FAIL single_busy: %0d cycles, required %0d", nb, 2 + 4 * NW); end
    tests++;
    if (nd != 1) begin fails++; $display("FAIL single_done: %0d pulses, required 1", nd); end
    e = model(NW);
    tests++;
    if (q.size() != e.size()) begin fails++; $display("FAIL single_len: %0d bytes, required %0d", q.size(), e.size()); end
    else foreach (e[i]) begin
      tests++;
      if (q[i] !== e[i]) begin fails++; $display("FAIL single_byte%0d: got %02h required %02h", i, q[i], e[i]); end
    end
  endtask

  task automatic test_saturation;
    int nb, nd;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hFF; mem[2] = 8'hFF; mem[3] = 8'hFE;
    tx_ready = 1;
    run_frame(200, nb, nd);
    e = model(NW);
    tests++;
    if (q.size() != e.size()) begin fails++; $display("FAIL sat_len: %0d bytes, required %0d", q.size(), e.size()); end
    else begin
      foreach (e[i]) begin
        tests++;
        if (q[i] !== e[i]) begin fails++; $display("FAIL sat_byte%0d: got %02h required %02h", i, q[i], e[i]); end
      end
      tests++;
      if (q[6] !== 8'hFE || q[8] !== 8'hFE) begin
        fails++;
        $display("FAIL sat_words23: got %02h %02h required fe fe", q[6], q[8]);
      end
    end
  endtask

  task automatic test_backpressure;
    int nb, nd;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
      mem[$urandom_range(0, NW - 1)] = 8'hFF;
      rand_ready = 1;
      run_frame(400, nb, nd);
      rand_ready = 0; tx_ready = 1;
      tests++;
      if (busy !== 1'b0 || nd != 1) begin
        fails++;
        $display("FAIL bp_complete%0d: busy=%0b done=%0d, required 0 1", f, busy, nd);
      end
      e = model(NW);
      tests++;
      if (q.size() != e.size()) begin fails++; $display("FAIL bp_len%0d: %0d bytes, required %0d", f, q.size(), e.size()); end
      else foreach (e[i]) begin
        tests++;
        if (q[i] !== e[i]) begin fails++; $display("FAIL bp_byte%0d_%0d: got %02h required %02h", f, i, q[i], e[i]); end
      end
    end
  endtask

  task automatic test_start_ignored;
    int nb = 0, nd = 0;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    tx_ready = 1; q.delete();
    @(posedge clk_in); #1 start = 1;
    @(posedge clk_in); #1 start = 0;
    fork
      begin
        repeat (8) @(posedge clk_in);
        #1 start = 1;
        @(posedge clk_in);
        #1 start = 0;
      end
    join_none
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_in);
      if (busy) nb++;
      if (frame_done) nd++;
    end
    tests++;
    if (nb != 2 + 4 * NW || nd != 1) begin
      fails++;
      $display("FAIL ignore_start: busy=%0d done=%0d, required %0d 1", nb, nd, 2 + 4 * NW);
    end
    e = model(NW);
    tests++;
    if (q.size() != e.size()) begin fails++; $display("FAIL ignore_len: %0d bytes, required %0d", q.size(), e.size()); end
    else foreach (e[i]) begin
      tests++;
      if (q[i] !== e[i]) begin fails++; $display("FAIL ignore_byte%0d: got %02h required %02h", i, q[i], e[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int nb, nd;
    logic [7:0] d1;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    d1 = mem[1] == 8'hFF ? 8'hFE : mem[1];
    tx_ready = 1; q.delete();
    @(posedge clk_in); #1 start = 1;
    @(posedge clk_in); #1 start = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_in); #1;
      if (q.size() == 4) break;
    end
    tx_ready = 0;
    #1;
    tests++;
    if (tx_valid !== 1'b1 || tx_data !== d1) begin
      fails++;
      $display("FAIL rst_mid_pos: valid=%0b data=%02h, required 1 %02h", tx_valid, tx_data, d1);
    end
    reset = 1;
    #1;
    tests++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_async: valid=%0b busy=%0b, required 0 0", tx_valid, busy);
    end
    repeat (2) @(posedge clk_in);
    #1 reset = 0; tx_ready = 1;
    run_frame(200, nb, nd);
    e = model(NW);
    tests++;
    if (q.size() != e.size()) begin fails++; $display("FAIL rst_mid_len: %0d bytes, required %0d", q.size(), e.size()); end
    else foreach (e[i]) begin
      tests++;
      if (q[i] !== e[i]) begin fails++; $display("FAIL rst_mid_byte%0d: got %02h required %02h", i, q[i], e[i]); end
    end
  endtask

  task automatic test_periodic;
    int nd = 0;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    mem[1] = 8'hFF;
    reset = 1;
    @(posedge clk_in); @(posedge clk_in); #1;
    qp.delete(); done_cyc.delete(); sync_cyc.delete();
    reset = 0;
    for (int i = 0; i < 100 && !frame_done_p; i++) @(negedge clk_in);
    repeat (P) @(posedge clk_in);
    #1 start_p = 1;
    @(posedge clk_in);
    #1 start_p = 0;
    for (int i = 0; i < 200 && nd < 2; i++) begin
      @(negedge clk_in);
      if (frame_done_p) nd++;
    end
    #1;
    tests++;
    if (done_cyc.size() != 3 || sync_cyc.size() != 3) begin
      fails++;
      $display("FAIL per_count: %0d done %0d sync, required 3 3", done_cyc.size(), sync_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (done_cyc[k] - sync_cyc[k] + 1 != 2 + 4 * NWP) begin
          fails++;
          $display("FAIL per_len%0d: %0d cycles, required %0d", k, done_cyc[k] - sync_cyc[k] + 1, 2 + 4 * NWP);
        end
      end
      for (int k = 1; k < 3; k++) begin
        tests++;
        if (sync_cyc[k] - done_cyc[k - 1] != P + 1) begin
          fails++;
          $display("FAIL per_gap%0d: %0d cycles, required %0d", k, sync_cyc[k] - done_cyc[k - 1], P + 1);
        end
      end
    end
    e = model(NWP);
    tests++;
    if (qp.size() != 3 * e.size()) begin fails++; $display("FAIL per_bytes: %0d bytes, required %0d", qp.size(), 3 * e.size()); end
    else for (int i = 0; i < qp.size(); i++) begin
      tests++;
      if (qp[i] !== e[i % e.size()]) begin
        fails++;
        $display("FAIL per_byte%0d: got %02h required %02h", i, qp[i], e[i % e.size()]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_saturation;
    test_backpressure;
    test_start_ignored;
    test_reset_mid;
    test_periodic;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
